// File: rtl/tx_ser_pkg.sv
// tx_ser_pkg: shared definitions for the word serializer.
//   tx_state_t     : serializer FSM states (idle, header bits, data bits)
//   HEADER_LEN     : number of header bits sent ahead of each word
//   FRAME_LEN      : header + data bits for the default word width
//   DEFAULT_HEADER : frame header pattern, sent MSB-first
//   frame_len()    : frame length for an arbitrary data width
package tx_ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } tx_state_t;

   localparam int         HEADER_LEN         = 8;
   localparam int         DEFAULT_DATA_WIDTH = 32;
   localparam int         FRAME_LEN          = HEADER_LEN + DEFAULT_DATA_WIDTH;
   localparam logic [7:0] DEFAULT_HEADER     = 8'hA5;

   function automatic int frame_len(input int data_width);
      return HEADER_LEN + data_width;
   endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// tx_word_fifo: word FIFO with synchronous push/pop and a registered head.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   push        : write push_data (ignored while full)
//   push_data   : word to store
//   pop         : consume the head word (ignored while head_valid=0)
//   head_data   : registered head word
//   head_valid  : head_data holds a stored word that may be popped
//   level       : number of words stored
//   full, empty : status derived from level
module tx_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LEVEL_W = AW + 1;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [LEVEL_W-1:0] count_reg, count_next, count_after_pop;
   logic               head_valid_reg;
   logic [WIDTH-1:0]   head_reg;
   logic               push_ok, pop_ok;

   // Both operations are judged against the state before this edge.
   assign full    = (count_reg == LEVEL_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && head_valid_reg;

   assign rd_ptr_next     = rd_ptr_reg + (pop_ok ? AW'(1) : AW'(0));
   assign count_after_pop = pop_ok ? count_reg - LEVEL_W'(1) : count_reg;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok)
         count_next = count_reg + LEVEL_W'(1);
      else if (pop_ok && !push_ok)
         count_next = count_reg - LEVEL_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         head_valid_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         // Only words already written before this edge can become the head,
         // so a fresh word reaches the head one cycle after it lands in mem.
         head_valid_reg <= (count_after_pop != '0);
      end
   end

   // Storage and registered head read carry no reset.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= push_data;
      head_reg <= mem[rd_ptr_next];
   end

   assign head_data  = head_reg;
   assign head_valid = head_valid_reg;
   assign level      = count_reg;

endmodule

// File: rtl/tx_word_serializer.sv
// tx_word_serializer: buffers command words and sends each one as a serial
// frame {HEADER, word}, MSB-first, one bit per bit_tick.
//   ACLK, ARESETN : clock (rising edge), asynchronous active-low reset
//   wr_valid      : push strobe, wr_data is the word
//   wr_ready      : FIFO not full
//   tx_en         : allow new frames to start
//   bit_tick      : one-cycle strobe per serial bit period
//   clr_ovf       : clear the sticky overflow flag
//   tx_bit        : registered serial output
//   tx_busy       : a frame is in progress
//   fifo_level    : words buffered
//   overflow      : a push was dropped because the FIFO was full
module tx_word_serializer
   import tx_ser_pkg::*;
#(
   parameter int         DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          wr_valid,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          wr_ready,
   input  logic                          tx_en,
   input  logic                          bit_tick,
   input  logic                          clr_ovf,
   output logic                          tx_bit,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int FRAME_BITS = frame_len(DATA_WIDTH);
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   tx_state_t              state_reg, state_next;
   logic [FRAME_BITS-1:0]  shift_reg, shift_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   tx_bit_reg, tx_bit_next;
   logic                   overflow_reg, overflow_next;

   logic                   fifo_pop, fifo_full, fifo_empty, head_valid;
   logic [DATA_WIDTH-1:0]  head_data;
   logic                   start_ok, frame_boundary;

   tx_word_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (ACLK),
      .rst_n      (ARESETN),
      .push       (wr_valid),
      .push_data  (wr_data),
      .pop        (fifo_pop),
      .head_data  (head_data),
      .head_valid (head_valid),
      .level      (fifo_level),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign wr_ready = !fifo_full;
   assign start_ok = tx_en && !fifo_empty && head_valid;
   // cnt_reg counts bits already sent; at FRAME_BITS the tick that follows
   // either starts the next frame directly or returns to idle.
   assign frame_boundary = (state_reg == ST_IDLE) || (cnt_reg == CNT_W'(FRAME_BITS));

   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      cnt_next    = cnt_reg;
      tx_bit_next = tx_bit_reg;
      fifo_pop    = 1'b0;
      if (bit_tick) begin
         if (frame_boundary) begin
            if (start_ok) begin
               // First header bit goes out now; the rest is pre-shifted.
               fifo_pop    = 1'b1;
               tx_bit_next = HEADER[7];
               shift_next  = {HEADER[6:0], head_data, 1'b0};
               cnt_next    = CNT_W'(1);
               state_next  = ST_HEADER;
            end else begin
               tx_bit_next = 1'b0;
               cnt_next    = '0;
               state_next  = ST_IDLE;
            end
         end else begin
            tx_bit_next = shift_reg[FRAME_BITS-1];
            shift_next  = {shift_reg[FRAME_BITS-2:0], 1'b0};
            cnt_next    = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(HEADER_LEN - 1))
               state_next = ST_DATA;
         end
      end
   end

   // A dropped push in the same cycle as clr_ovf keeps the flag set.
   always_comb begin
      overflow_next = overflow_reg;
      if (wr_valid && fifo_full)
         overflow_next = 1'b1;
      else if (clr_ovf)
         overflow_next = 1'b0;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         tx_bit_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         cnt_reg      <= cnt_next;
         tx_bit_reg   <= tx_bit_next;
         overflow_reg <= overflow_next;
      end
   end

   assign tx_bit   = tx_bit_reg;
   assign tx_busy  = (state_reg != ST_IDLE);
   assign overflow = overflow_reg;

endmodule
